text_buffer_writer: RTL

- Terminal-style character sink that maintains the CHARS_VERT x CHARS_HORZ ASCII screen array consumed directly by the VGA text-mode draw stage.
- Accepts a byte stream from the CPU/output port over a valid/ready handshake.
- Handles cursor advance, CR, LF, backspace, form-feed clear and hardware scroll.
- Runs in the 25 MHz pixel clock domain. The draw stage reads char_buffer combinationally; this block is its only writer.

---
 rtl/text_buffer_writer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/text_buffer_writer.sv
// text_buffer_writer
// Terminal-style character sink that owns the text-mode screen array read by
// the VGA draw stage. Bytes arrive over valid/ready; printable codes are
// written at the cursor, control codes move the cursor, LF on the last row
// scrolls the screen one row per cycle and FF clears it one row per cycle.
module text_buffer_writer #(
    parameter int                    ASCII_SIZE = 8,
    parameter int                    CHARS_HORZ = 80,
    parameter int                    CHARS_VERT = 30,
    parameter logic [ASCII_SIZE-1:0] BLANK_CHAR = 8'h20
) (
    input  logic                                                 clk_25M,
    input  logic                                                 rst_n,
    input  logic [ASCII_SIZE-1:0]                                in_data,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    output logic [CHARS_VERT-1:0][CHARS_HORZ-1:0][ASCII_SIZE-1:0] char_buffer,
    output logic [$clog2(CHARS_VERT)-1:0]                        cursor_row,
    output logic [$clog2(CHARS_HORZ)-1:0]                        cursor_col,
    output logic                                                 busy
);

    localparam int ROW_W = $clog2(CHARS_VERT);
    localparam int COL_W = $clog2(CHARS_HORZ);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(CHARS_VERT - 1);
    localparam logic [ROW_W-1:0] ROW_PEN  = ROW_W'(CHARS_VERT - 2);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(CHARS_HORZ - 1);

    localparam logic [ASCII_SIZE-1:0] CH_BS  = ASCII_SIZE'(8'h08);
    localparam logic [ASCII_SIZE-1:0] CH_LF  = ASCII_SIZE'(8'h0A);
    localparam logic [ASCII_SIZE-1:0] CH_FF  = ASCII_SIZE'(8'h0C);
    localparam logic [ASCII_SIZE-1:0] CH_CR  = ASCII_SIZE'(8'h0D);
    localparam logic [ASCII_SIZE-1:0] PR_LO  = ASCII_SIZE'(8'h20);
    localparam logic [ASCII_SIZE-1:0] PR_HI  = ASCII_SIZE'(8'h7E);

    localparam logic [CHARS_HORZ-1:0][ASCII_SIZE-1:0] BLANK_ROW = {CHARS_HORZ{BLANK_CHAR}};

    typedef enum logic [1:0] {IDLE, SCROLL, CLR_LAST, CLEAR} state_t;

    state_t                                                state_q;
    logic [CHARS_VERT-1:0][CHARS_HORZ-1:0][ASCII_SIZE-1:0] buf_q;
    logic [ROW_W-1:0]                                      row_q;
    logic [COL_W-1:0]                                      col_q;
    logic [ROW_W-1:0]                                      idx_q;
    logic                                                  ready_q;

    logic accept;
    logic is_print;
    logic do_nl;

    // Decode the incoming byte; a newline is due on LF or on a printable in the last column
    always_comb begin
        accept   = in_valid && (state_q == IDLE);
        is_print = (in_data >= PR_LO) && (in_data <= PR_HI);
        do_nl    = accept && ((is_print && (col_q == COL_LAST)) || (in_data == CH_LF));
    end

    // Screen, cursor and sequencing FSM; scroll and clear walk one row per cycle
    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= {CHARS_VERT{BLANK_ROW}};
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            state_q <= IDLE;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_print) begin
                            buf_q[row_q][col_q] <= in_data;
                            col_q <= (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
                        end else if (in_data == CH_CR) begin
                            col_q <= '0;
                        end else if ((in_data == CH_BS) && (col_q != '0)) begin
                            col_q                          <= col_q - COL_W'(1);
                            buf_q[row_q][col_q - COL_W'(1)] <= BLANK_CHAR;
                        end else if (in_data == CH_FF) begin
                            idx_q   <= '0;
                            state_q <= CLEAR;
                            ready_q <= 1'b0;
                        end
                    end
                    // The cursor stays on the last row; the content moves up instead
                    if (do_nl) begin
                        if (row_q != ROW_LAST) begin
                            row_q <= row_q + ROW_W'(1);
                        end else begin
                            idx_q   <= '0;
                            state_q <= SCROLL;
                            ready_q <= 1'b0;
                        end
                    end
                end
                SCROLL: begin
                    buf_q[idx_q] <= buf_q[idx_q + ROW_W'(1)];
                    if (idx_q == ROW_PEN) begin
                        state_q <= CLR_LAST;
                    end else begin
                        idx_q <= idx_q + ROW_W'(1);
                    end
                end
                CLR_LAST: begin
                    buf_q[ROW_LAST] <= BLANK_ROW;
                    state_q         <= IDLE;
                    ready_q         <= 1'b1;
                end
                CLEAR: begin
                    buf_q[idx_q] <= BLANK_ROW;
                    if (idx_q == ROW_LAST) begin
                        row_q   <= '0;
                        col_q   <= '0;
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + ROW_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = ready_q;
    assign busy        = ~ready_q;
    assign char_buffer = buf_q;
    assign cursor_row  = row_q;
    assign cursor_col  = col_q;

endmodule
